// File: rtl/mdu_issue_ctrl_if.sv
// Issue-side signal bundle between the E-stage pipeline and mdu_issue_ctrl.
// The pipeline drives the request/opcode side (master); the controller drives issue, interlock and trace outputs (slave).
interface mdu_issue_ctrl_if;
    logic        Req;
    logic        e_op_valid;
    logic [3:0]  e_op;
    logic        d_md_use;
    logic [3:0]  MDOp;
    logic        start;
    logic        stall_md;
    logic        busy_shadow;
    logic        done;
    logic        proto_err;
    logic [15:0] mul_cnt;
    logic [15:0] div_cnt;
    logic [1:0]  dbg_state;

    modport master (
        output Req, e_op_valid, e_op, d_md_use,
        input  MDOp, start, stall_md, busy_shadow, done, proto_err,
               mul_cnt, div_cnt, dbg_state
    );

    modport slave (
        input  Req, e_op_valid, e_op, d_md_use,
        output MDOp, start, stall_md, busy_shadow, done, proto_err,
               mul_cnt, div_cnt, dbg_state
    );
endinterface

// File: rtl/mdu_issue_ctrl.sv
// MDU issue/interlock controller: filters E-stage mul/div ops against Req, drives MDOp/start,
// and keeps a cycle-exact shadow of MDU occupancy to stall mul/div-class ops waiting in D.
module mdu_issue_ctrl #(
    parameter int MUL_LAT = 5,
    parameter int DIV_LAT = 10
) (
    input  logic             clk,
    input  logic             reset,
    mdu_issue_ctrl_if.slave  md
);
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_MUL_RUN = 2'd1,
        S_DIV_RUN = 2'd2
    } state_t;

    localparam logic [3:0] MUL_LAT_C = 4'(MUL_LAT);
    localparam logic [3:0] DIV_LAT_C = 4'(DIV_LAT);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [3:0]  r_cnt;
    logic [3:0]  w_cnt_nxt;
    logic        r_busy;
    logic        r_done;
    logic        w_done_nxt;
    logic        r_perr;
    logic [15:0] r_mul_cnt;
    logic [15:0] r_div_cnt;
    logic        w_iss;
    logic        w_start;
    logic        w_viol;
    logic        w_is_div;

    // Handshake: issue happens only when E presents a valid op, Req is low and
    // the MDU is idle; an attempt while occupied is dropped and flagged.
    always_comb begin
        w_iss       = md.e_op_valid & ~md.Req & (r_state == S_IDLE);
        w_start     = w_iss & (md.e_op <= 4'b0011);
        w_viol      = md.e_op_valid & ~md.Req & (r_state != S_IDLE);
        w_is_div    = md.e_op[1];
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_done_nxt  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_start) begin
                    if (w_is_div) begin
                        w_state_nxt = S_DIV_RUN;
                        w_cnt_nxt   = DIV_LAT_C;
                    end else begin
                        w_state_nxt = S_MUL_RUN;
                        w_cnt_nxt   = MUL_LAT_C;
                    end
                end
            end
            S_MUL_RUN, S_DIV_RUN: begin
                // The MDU freezes while Req is high, so the shadow freezes too.
                if (!md.Req) begin
                    if (r_cnt == 4'd1) begin
                        w_state_nxt = S_IDLE;
                        w_cnt_nxt   = 4'd0;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_cnt_nxt = r_cnt - 4'd1;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_cnt     <= 4'd0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_perr    <= 1'b0;
            r_mul_cnt <= 16'd0;
            r_div_cnt <= 16'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_busy  <= (w_state_nxt != S_IDLE);
            r_done  <= w_done_nxt;
            r_perr  <= r_perr | w_viol;
            if (w_start && !w_is_div && r_mul_cnt != 16'hFFFF)
                r_mul_cnt <= r_mul_cnt + 16'd1;
            if (w_start && w_is_div && r_div_cnt != 16'hFFFF)
                r_div_cnt <= r_div_cnt + 16'd1;
        end
    end

    assign md.MDOp        = w_iss ? md.e_op : 4'b1111;
    assign md.start       = w_start;
    assign md.stall_md    = md.d_md_use & (w_start | r_busy);
    assign md.busy_shadow = r_busy;
    assign md.done        = r_done;
    assign md.proto_err   = r_perr;
    assign md.mul_cnt     = r_mul_cnt;
    assign md.div_cnt     = r_div_cnt;
    assign md.dbg_state   = r_state;
endmodule

// File: tb/tb_mdu_issue_ctrl.sv
// Directed bench for mdu_issue_ctrl: drivers queue hand-computed expectations,
// a negedge monitor pops and compares start/done events and per-cycle levels.
module tb_mdu_issue_ctrl;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mdu_issue_ctrl_if md();

    mdu_issue_ctrl #(.MUL_LAT(5), .DIV_LAT(10)) dut (
        .clk   (clk),
        .reset (reset),
        .md    (md)
    );

    localparam int SIG_MDOP  = 0;
    localparam int SIG_START = 1;
    localparam int SIG_STALL = 2;
    localparam int SIG_BUSY  = 3;
    localparam int SIG_DONE  = 4;
    localparam int SIG_PERR  = 5;
    localparam int SIG_MUL   = 6;
    localparam int SIG_DIV   = 7;
    localparam int SIG_STATE = 8;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_fail = 0;

    logic [51:0] exp_q[$];
    logic [35:0] start_q[$];
    logic [31:0] done_q[$];

    function automatic string sig_name(int id);
        case (id)
            SIG_MDOP:  return "MDOp";
            SIG_START: return "start";
            SIG_STALL: return "stall_md";
            SIG_BUSY:  return "busy_shadow";
            SIG_DONE:  return "done";
            SIG_PERR:  return "proto_err";
            SIG_MUL:   return "mul_cnt";
            SIG_DIV:   return "div_cnt";
            default:   return "state";
        endcase
    endfunction

    function automatic logic [15:0] sig_val(int id);
        case (id)
            SIG_MDOP:  return {12'b0, md.MDOp};
            SIG_START: return {15'b0, md.start};
            SIG_STALL: return {15'b0, md.stall_md};
            SIG_BUSY:  return {15'b0, md.busy_shadow};
            SIG_DONE:  return {15'b0, md.done};
            SIG_PERR:  return {15'b0, md.proto_err};
            SIG_MUL:   return md.mul_cnt;
            SIG_DIV:   return md.div_cnt;
            default:   return {14'b0, md.dbg_state};
        endcase
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp, int c);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cycle %0d: got 0x%0h expected 0x%0h", name, c, act, exp);
        end
    endtask

    // Level expectations are kept sorted by cycle so drivers may push in any order.
    task automatic lvl(int c, int id, logic [15:0] v);
        int i;
        logic [31:0] cc;
        logic [3:0]  ii;
        cc = c;
        ii = id[3:0];
        i = 0;
        while (i < exp_q.size() && exp_q[i][51:20] <= cc) i++;
        exp_q.insert(i, {cc, ii, v});
    endtask

    task automatic exp_start(int c, logic [3:0] op);
        logic [31:0] cc;
        cc = c;
        start_q.push_back({cc, op});
    endtask

    task automatic exp_done(int c);
        done_q.push_back(c);
    endtask

    logic [51:0] m_e;
    logic [35:0] m_s;
    logic [31:0] m_d;

    always @(negedge clk) begin
        if (md.start === 1'b1) begin
            if (start_q.size() == 0) begin
                check("start_unexpected", {31'b0, md.start}, 32'd0, cyc);
            end else begin
                m_s = start_q.pop_front();
                check("start_cycle", cyc, m_s[35:4], cyc);
                check("start_mdop", {28'b0, md.MDOp}, {28'b0, m_s[3:0]}, cyc);
            end
        end
        if (md.done === 1'b1) begin
            if (done_q.size() == 0) begin
                check("done_unexpected", {31'b0, md.done}, 32'd0, cyc);
            end else begin
                m_d = done_q.pop_front();
                check("done_cycle", cyc, m_d, cyc);
            end
        end
        while (exp_q.size() > 0 && exp_q[0][51:20] <= cyc) begin
            m_e = exp_q.pop_front();
            check(sig_name(int'(m_e[19:16])), {16'b0, sig_val(int'(m_e[19:16]))},
                  {16'b0, m_e[15:0]}, cyc);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        md.Req        = 1'b0;
        md.e_op_valid = 1'b0;
        md.e_op       = 4'b0000;
        md.d_md_use   = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog");
    end

    int b;

    initial begin
        idle_inputs();
        reset = 1'b1;

        // Reset state
        do_reset();
        b = cyc;
        lvl(b, SIG_MDOP, 16'hF);  lvl(b, SIG_START, 0); lvl(b, SIG_BUSY, 0);
        lvl(b, SIG_MUL, 0);       lvl(b, SIG_DIV, 0);   lvl(b, SIG_PERR, 0);
        lvl(b, SIG_STALL, 0);     lvl(b, SIG_DONE, 0);  lvl(b, SIG_STATE, 0);
        tick();
        tick();

        // MULT at b+2 with D-stage mul/div use from b+2
        do_reset();
        b = cyc;
        exp_start(b + 2, 4'h0);
        exp_done(b + 8);
        lvl(b + 2, SIG_BUSY, 0);
        lvl(b + 2, SIG_MUL, 0);
        for (int k = 2; k <= 7; k++) lvl(b + k, SIG_STALL, 1);
        for (int k = 3; k <= 7; k++) lvl(b + k, SIG_BUSY, 1);
        lvl(b + 3, SIG_MUL, 1);
        lvl(b + 8, SIG_STALL, 0);
        lvl(b + 8, SIG_BUSY, 0);
        lvl(b + 8, SIG_MUL, 1);
        for (int i = 0; i <= 10; i++) begin
            md.e_op_valid = (i == 2);
            md.e_op       = 4'h0;
            md.d_md_use   = (i >= 2 && i <= 9);
            tick();
        end

        // DIVU at b+2, Req high during b+5..b+6 stretches the run by two
        do_reset();
        b = cyc;
        exp_start(b + 2, 4'h3);
        exp_done(b + 15);
        lvl(b + 2, SIG_BUSY, 0);
        for (int k = 3; k <= 14; k++) lvl(b + k, SIG_BUSY, 1);
        lvl(b + 15, SIG_BUSY, 0);
        lvl(b + 15, SIG_DIV, 1);
        lvl(b + 15, SIG_MUL, 0);
        for (int i = 0; i <= 17; i++) begin
            md.e_op_valid = (i == 2);
            md.e_op       = 4'h3;
            md.Req        = (i == 5 || i == 6);
            tick();
        end
        idle_inputs();

        // MTHI issue, the same op masked by Req, a no-op code, then MFLO with D use
        do_reset();
        b = cyc;
        lvl(b + 1, SIG_MDOP, 16'h6);  lvl(b + 1, SIG_START, 0);
        lvl(b + 2, SIG_STATE, 0);     lvl(b + 2, SIG_BUSY, 0);
        lvl(b + 2, SIG_MDOP, 16'hF);  lvl(b + 2, SIG_START, 0);
        lvl(b + 3, SIG_MDOP, 16'hA);  lvl(b + 3, SIG_START, 0);
        lvl(b + 4, SIG_BUSY, 0);      lvl(b + 4, SIG_MDOP, 16'h5);
        lvl(b + 4, SIG_STALL, 0);
        lvl(b + 5, SIG_PERR, 0);      lvl(b + 5, SIG_MUL, 0);
        lvl(b + 5, SIG_DIV, 0);
        for (int i = 0; i <= 5; i++) begin
            md.e_op_valid = (i >= 1 && i <= 4);
            md.Req        = (i == 2);
            md.d_md_use   = (i == 4);
            md.e_op       = (i == 3) ? 4'hA : ((i == 4) ? 4'h5 : 4'h6);
            tick();
        end
        idle_inputs();

        // DIV run with an illegal MULT attempt, then MULTU issued in the done cycle
        do_reset();
        b = cyc;
        exp_start(b + 2, 4'h2);
        exp_done(b + 13);
        exp_start(b + 13, 4'h1);
        exp_done(b + 19);
        lvl(b + 5, SIG_MDOP, 16'hF);
        lvl(b + 5, SIG_STALL, 1);
        lvl(b + 5, SIG_PERR, 0);
        for (int k = 3; k <= 12; k++) lvl(b + k, SIG_BUSY, 1);
        lvl(b + 6, SIG_PERR, 1);
        lvl(b + 13, SIG_BUSY, 0);
        lvl(b + 13, SIG_PERR, 1);
        lvl(b + 13, SIG_MUL, 0);
        lvl(b + 14, SIG_MUL, 1);
        lvl(b + 14, SIG_DIV, 1);
        for (int k = 14; k <= 18; k++) lvl(b + k, SIG_BUSY, 1);
        lvl(b + 19, SIG_BUSY, 0);
        lvl(b + 20, SIG_PERR, 1);
        for (int i = 0; i <= 21; i++) begin
            md.e_op_valid = (i == 2 || i == 5 || i == 13);
            md.e_op       = (i == 2) ? 4'h2 : ((i == 13) ? 4'h1 : 4'h0);
            md.d_md_use   = (i == 5);
            tick();
        end
        idle_inputs();

        // Reset in the middle of a DIV run
        do_reset();
        b = cyc;
        exp_start(b + 2, 4'h2);
        lvl(b, SIG_PERR, 0);
        lvl(b + 3, SIG_DIV, 1);
        lvl(b + 4, SIG_BUSY, 1);
        lvl(b + 5, SIG_BUSY, 0);
        lvl(b + 5, SIG_DIV, 0);
        lvl(b + 5, SIG_STATE, 0);
        lvl(b + 5, SIG_DONE, 0);
        lvl(b + 13, SIG_BUSY, 0);
        for (int i = 0; i <= 15; i++) begin
            md.e_op_valid = (i == 2);
            md.e_op       = 4'h2;
            reset         = (i == 4);
            tick();
        end
        reset = 1'b0;
        idle_inputs();

        tick();
        tick();
        check("exp_q_left", exp_q.size(), 32'd0, cyc);
        check("start_q_left", start_q.size(), 32'd0, cyc);
        check("done_q_left", done_q.size(), 32'd0, cyc);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
